// File: rtl/tictactoe_pkg.sv
// Shared constants, selector state encoding and grid helpers
// for the tic-tac-toe input path.
package tictactoe_pkg;

    localparam int GRID_DIM   = 3;
    localparam int CELL_COUNT = 9;

    localparam logic [3:0] CELL_0 = 4'd0;
    localparam logic [3:0] CELL_1 = 4'd1;
    localparam logic [3:0] CELL_2 = 4'd2;
    localparam logic [3:0] CELL_3 = 4'd3;
    localparam logic [3:0] CELL_4 = 4'd4;
    localparam logic [3:0] CELL_5 = 4'd5;
    localparam logic [3:0] CELL_6 = 4'd6;
    localparam logic [3:0] CELL_7 = 4'd7;
    localparam logic [3:0] CELL_8 = 4'd8;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int BTN_COUNT  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2
    } sel_state_t;

    function automatic logic [3:0] cell_index(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return 4'(row) * 4'(GRID_DIM) + 4'(col);
    endfunction

    function automatic logic [CELL_COUNT-1:0] cell_onehot(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [CELL_COUNT-1:0] v;
        v = CELL_COUNT'(1) << cell_index(row, col);
        return v;
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'(GRID_DIM - 1)) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'(GRID_DIM - 1) : v - 2'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-run debouncer for one raw button;
// exports the accepted level and a one-cycle rising-edge event.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample that matches the current level restarts the run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_rise <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == LIMIT) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/cell_selector.sv
// Button-driven 3x3 cursor and one-hot cell select for the game FSM.
// Optional CELL_SELECT_BLOCK_OCCUPIED_EN suppresses picks of taken cells.
module cell_selector
    import tictactoe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_center,
    input  logic [CELL_COUNT-1:0] occupied,
    output logic [CELL_COUNT-1:0] cuadro,
    output logic [CELL_COUNT-1:0] cursor,
    output logic [1:0]            cursor_row,
    output logic [1:0]            cursor_col,
    output logic                  busy
);

    localparam int HW =
        (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [BTN_COUNT-1:0]  w_raw;
    logic [BTN_COUNT-1:0]  w_level;
    logic [BTN_COUNT-1:0]  w_rise;
    logic [3:0]            w_cur_idx;
    logic                  w_occ_hit;
    logic                  w_nav_en;
    logic                  w_unused;
    sel_state_t            r_state;
    sel_state_t            w_next_state;
    logic [1:0]            r_row;
    logic [1:0]            r_col;
    logic [HW-1:0]         r_hold;
    logic [CELL_COUNT-1:0] r_sel;

    assign w_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk  (clk_100MHz),
            .i_rst  (reset),
            .i_btn  (w_raw[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_cur_idx = cell_index(r_row, r_col);

`ifdef CELL_SELECT_BLOCK_OCCUPIED_EN
    assign w_occ_hit = occupied[w_cur_idx];
    assign w_unused  = ^w_level[BTN_RIGHT:BTN_UP];
`else
    assign w_occ_hit = 1'b0;
    assign w_unused  = ^{occupied, w_level[BTN_RIGHT:BTN_UP]};
`endif

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_rise[BTN_CENTER]) begin
                    w_next_state = w_occ_hit ? GUARD : PULSE;
                end
            end
            PULSE: begin
                if (r_hold == '0) begin
                    w_next_state = GUARD;
                end
            end
            GUARD: begin
                if (!w_level[BTN_CENTER]) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cuadro     = (r_state == PULSE) ? r_sel : '0;
        busy       = (r_state != IDLE);
        cursor     = cell_onehot(r_row, r_col);
        cursor_row = r_row;
        cursor_col = r_col;
    end

    // A center event in the same cycle swallows any navigation.
    assign w_nav_en = (r_state == IDLE) && !w_rise[BTN_CENTER];

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_row <= 2'd1;
            r_col <= 2'd1;
        end else if (w_nav_en) begin
            if (w_rise[BTN_UP]) begin
                r_row <= wrap_dec(r_row);
            end else if (w_rise[BTN_DOWN]) begin
                r_row <= wrap_inc(r_row);
            end else if (w_rise[BTN_LEFT]) begin
                r_col <= wrap_dec(r_col);
            end else if (w_rise[BTN_RIGHT]) begin
                r_col <= wrap_inc(r_col);
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
            r_sel  <= '0;
        end else if (r_state == IDLE && w_next_state == PULSE) begin
            r_hold <= HOLD_LOAD;
            r_sel  <= cell_onehot(r_row, r_col);
        end else if (r_state == PULSE && r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

endmodule

// File: tb/tb_cell_selector.sv
// Directed bench for cell_selector with a cycle-level reference model
// of debounce, cursor navigation and the select pulse.
module tb_cell_selector;

    localparam int DB   = 4;
    localparam int HOLD = 16;

    localparam int M_IDLE  = 0;
    localparam int M_PULSE = 1;
    localparam int M_GUARD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = '0;
    logic [8:0] occupied = '0;
    logic [8:0] cuadro;
    logic [8:0] cursor;
    logic [1:0] cursor_row;
    logic [1:0] cursor_col;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cell_selector #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .btn_center(btn[4]),
        .occupied  (occupied),
        .cuadro    (cuadro),
        .cursor    (cursor),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: buttons seen through a 2-cycle delay, accepted
    // after DB equal samples differing from the level.
    int m_st, m_row, m_col, m_idx, m_left;
    int m_d1[5], m_d2[5], m_lvl[5], m_ev[5];
    int m_win[5][DB];

    task automatic model_init();
        m_st = M_IDLE; m_row = 1; m_col = 1; m_idx = 0; m_left = 0;
        for (int b = 0; b < 5; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_ev[b] = 0;
            for (int k = 0; k < DB; k++) m_win[b][k] = 0;
        end
    endtask

    task automatic model_step();
        int syn;
        int all_diff;
        case (m_st)
            M_IDLE: begin
                if (m_ev[4] != 0) begin
                    m_idx = m_row * 3 + m_col;
`ifdef CELL_SELECT_BLOCK_OCCUPIED_EN
                    if (occupied[m_idx]) m_st = M_GUARD;
                    else begin m_st = M_PULSE; m_left = HOLD; end
`else
                    m_st = M_PULSE; m_left = HOLD;
`endif
                end else if (m_ev[0] != 0) m_row = (m_row + 2) % 3;
                else if (m_ev[1] != 0) m_row = (m_row + 1) % 3;
                else if (m_ev[2] != 0) m_col = (m_col + 2) % 3;
                else if (m_ev[3] != 0) m_col = (m_col + 1) % 3;
            end
            M_PULSE: begin
                m_left--;
                if (m_left == 0) m_st = M_GUARD;
            end
            default: begin
                if (m_lvl[4] == 0) m_st = M_IDLE;
            end
        endcase
        for (int b = 0; b < 5; b++) begin
            syn = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = int'(btn[b]);
            for (int k = 0; k < DB - 1; k++) m_win[b][k] = m_win[b][k+1];
            m_win[b][DB-1] = syn;
            all_diff = 1;
            for (int k = 0; k < DB; k++)
                if (m_win[b][k] == m_lvl[b]) all_diff = 0;
            m_ev[b] = 0;
            if (all_diff != 0) begin
                m_lvl[b] = 1 - m_lvl[b];
                m_ev[b] = m_lvl[b];
            end
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_init();
            end else begin
                chk("m_cursor", cursor, 9'(1 << (m_row * 3 + m_col)));
                chk("m_row", {7'b0, cursor_row}, 9'(m_row));
                chk("m_col", {7'b0, cursor_col}, 9'(m_col));
                chk("m_cuadro", cuadro,
                    (m_st == M_PULSE) ? 9'(1 << m_idx) : 9'h000);
                chk("m_busy", {8'b0, busy}, 9'(m_st != M_IDLE));
                model_step();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        tick(hold);
        btn[b] = 1'b0;
        tick(10);
    endtask

    int pat[8] = '{1, 1, 0, 0, 1, 1, 1, 0};
    int hi, rises, nobusy, seen_busy, waited;
    logic prev;

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_cursor", cursor, 9'h010);
        chk("rst_row", {7'b0, cursor_row}, 9'd1);
        chk("rst_col", {7'b0, cursor_col}, 9'd1);
        chk("rst_cuadro", cuadro, 9'h000);
        chk("rst_busy", {8'b0, busy}, 9'd0);

        foreach (pat[i]) begin
            btn[3] = pat[i][0];
            tick(1);
        end
        press(3, 8);
        chk("bounce_right", cursor, 9'h020);
        chk("bounce_col", {7'b0, cursor_col}, 9'd2);
        press(3, 8);
        chk("right_wrap", cursor, 9'h008);

        do_reset();
        press(0, 8);
        chk("up_once", cursor, 9'h002);
        press(0, 8);
        chk("up_wrap", cursor, 9'h080);
        chk("up_wrap_row", {7'b0, cursor_row}, 9'd2);

        press(3, 8);
        chk("at_22", cursor, 9'h100);
        btn[4] = 1'b1;
        hi = 0; rises = 0; nobusy = 0; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (cuadro == 9'h100) hi++;
            if (cuadro != 0 && !prev) rises++;
            if (cuadro != 0 && !busy) nobusy++;
            prev = (cuadro != 0);
        end
        btn[4] = 1'b0;
        chk("pulse_len", 9'(hi), 9'd16);
        chk("pulse_once", 9'(rises), 9'd1);
        chk("busy_in_pulse", 9'(nobusy), 9'd0);
        tick(6);
        chk("busy_before_db", {8'b0, busy}, 9'd1);
        tick(1);
        chk("busy_after_db", {8'b0, busy}, 9'd0);
        tick(5);

        do_reset();
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        tick(8);
        btn = '0;
        tick(10);
        chk("prio_cursor", cursor, 9'h002);
        chk("prio_col", {7'b0, cursor_col}, 9'd1);

        btn[4] = 1'b1;
        waited = 0;
        while (cuadro == 0 && waited < 40) begin
            tick(1);
            waited++;
        end
        chk("pulse_start_timeout", 9'(cuadro != 0), 9'd1);
        tick(3);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_cuadro", cuadro, 9'h000);
        chk("async_rst_busy", {8'b0, busy}, 9'd0);
        btn = '0;
        tick(2);
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (cuadro != 0) hi++;
        end
        chk("no_resume", 9'(hi), 9'd0);
        chk("post_rst_cursor", cursor, 9'h010);

        occupied = 9'h010;
        btn[4] = 1'b1;
        hi = 0; seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (cuadro == 9'h010) hi++;
            if (busy) seen_busy = 1;
        end
        btn[4] = 1'b0;
        tick(15);
`ifdef CELL_SELECT_BLOCK_OCCUPIED_EN
        chk("occ_blocked", 9'(hi), 9'd0);
        chk("occ_busy", 9'(seen_busy), 9'd1);
`else
        chk("occ_ignored", 9'(hi), 9'd16);
        chk("occ_busy", 9'(seen_busy), 9'd1);
`endif
        chk("final_idle", {8'b0, busy}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
